stage_mem_arbiter: RTL and testbench
====================================

Name: stage_mem_arbiter

Overview:
Arbitrates the single shared cache/memory port between the stage 0 instruction fetch and the stage 1 operand fetch/store of the accumulator processor. It sequences each access through grant, address, hit-check and miss-wait phases, then returns read data with a one-cycle done pulse. Stage 1 has priority. A starvation counter guarantees stage 0 forward progress. It sits between the stage controllers (stage 0 and stage 1 FSMs) and the cache.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
MISS_WAIT, 4, cycles waited after a miss before memory data is valid (1..15)
STARVE_MAX, 3, consecutive stage-1 grants allowed while stage 0 is waiting

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous reset, active-low
s0_req  in  1  stage 0 access request, held until s0_done
s0_we  in  1  stage 0 write enable (1 = store)
s0_addr  in  ADDR_W  stage 0 address
s0_wdata  in  DATA_W  stage 0 write data
s1_req  in  1  stage 1 access request, held until s1_done
s1_we  in  1  stage 1 write enable
s1_addr  in  ADDR_W  stage 1 address
s1_wdata  in  DATA_W  stage 1 write data
s0_gnt  out  1  stage 0 owns the port (ACCESS..DONE)
s1_gnt  out  1  stage 1 owns the port
s0_done  out  1  one-cycle completion pulse to stage 0
s1_done  out  1  one-cycle completion pulse to stage 1
rdata  out  DATA_W  read data; valid when doneX is high, held afterwards
mem_en  out  1  memory/cache access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory/cache read data
cache_hit  in  1  cache hit, valid the cycle after mem_en
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. On clr=0 (asynchronous): state IDLE, all outputs 0, rdata 0, starve counter 0, wait counter 0.
- The state register is one-hot: IDLE, ACCESS, CHECK, WAIT, DONE.
- IDLE: sample s0_req/s1_req.
  - s1 only -> s1. s0 only -> s0.
  - Both -> s1, unless starve counter == STARVE_MAX, then s0.
  - On a grant: latch the owner, we, addr and wdata; set sX_gnt=1; go to ACCESS.
- ACCESS (1 cycle): mem_en=1; mem_we, mem_addr and mem_wdata come from the latched request. Go to CHECK.
- CHECK: mem_en=0.
  - cache_hit=1 -> capture mem_rdata into rdata (reads only) and go to DONE.
  - cache_hit=0 -> load the wait counter with MISS_WAIT and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, capture mem_rdata (reads only) and go to DONE.
- DONE (1 cycle): sX_done=1 for the owner. sX_gnt is cleared at the end of DONE. Always return to IDLE; requests are never sampled in DONE.
- Latency from request seen in IDLE to done: 3 cycles on a hit, 3+MISS_WAIT cycles on a miss. Minimum request-to-request spacing is 4 cycles.
- Writes follow the same sequence and cache_hit timing. rdata is not updated on writes.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each s1 grant made while s0_req=1.
  - Clears to 0 on any s0 grant.
  - Unchanged on an s1 grant while s0_req=0.
- A request dropped after grant does not abort the access. The done pulse is still issued.
- Request inputs changing after the grant are ignored, because the request is latched.
- clr asserted mid-access: immediate return to IDLE, no done pulse. The requester must re-issue.
- s0_gnt and s1_gnt are never both high.

Decomposition:
- Shared package (stage_pkg): one-hot state constants for IDLE/ACCESS/CHECK/WAIT/DONE, owner encoding (OWN_S0=0, OWN_S1=1), default widths.
- One natural sub-module, miss_wait_counter. It is a loadable down-counter with load, load value and a done-at-1 flag, reused later for other stage wait states.
- The arbitration decision stays inline.

Test Plan:
1. s1_req read addr 0x20, cache_hit=1 at CHECK, mem_rdata=0x5A -> s1_gnt from cycle 1, mem_en high for one cycle with addr 0x20, s1_done pulse at cycle 3, rdata=0x5A.
2. s0_req read addr 0x10, cache_hit=0, MISS_WAIT=4, mem_rdata=0xC3 at the last WAIT cycle -> s0_done at cycle 7, rdata=0xC3, busy high for cycles 1..7.
3. s0_req and s1_req held continuously with back-to-back accesses, STARVE_MAX=3 -> grant order s1,s1,s1,s0,s1,s1,s1,s0; never both gnt high.
4. s1 write addr 0x33, wdata 0x99 after a prior read of 0x5A -> mem_we=1 with 0x99 during ACCESS, s1_done pulses, rdata stays 0x5A.
5. clr pulsed low during WAIT of an s0 miss -> all outputs 0 immediately, no s0_done; a re-issued s0_req completes normally.
6. s1_req dropped during CHECK -> access completes, s1_done still pulses once, arbiter returns to IDLE and grants a pending s0.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared definitions for the stage controllers and the memory-port arbiter.
// State codes are one-hot; owner encoding selects which stage holds the port.
package stage_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_ACCESS = 5'b00010,
        ST_CHECK  = 5'b00100,
        ST_WAIT   = 5'b01000,
        ST_DONE   = 5'b10000
    } state_t;

    typedef enum logic {
        OWN_S0 = 1'b0,
        OWN_S1 = 1'b1
    } owner_t;

endpackage

// File: rtl/miss_wait_counter.sv
// Loadable down-counter with a flag raised while the count equals 1.
// The count stops at zero, so a held decrement never wraps.
module miss_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         at_one
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign at_one = (count == W'(1));

endmodule

// File: rtl/stage_mem_arbiter.sv
// Shares the single cache/memory port between stage 0 fetch and stage 1 operand access.
// Stage 1 wins ties unless stage 0 has been passed over STARVE_MAX times in a row.
//
// state  | meaning
// IDLE   | port free, sample requests
// ACCESS | mem_en strobe with the latched request
// CHECK  | look at cache_hit, capture data or start miss wait
// WAIT   | count down the miss latency
// DONE   | completion pulse to the owner, then back to IDLE
module stage_mem_arbiter
    import stage_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MISS_WAIT  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              s0_req,
    input  logic              s0_we,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_wdata,
    input  logic              s1_req,
    input  logic              s1_we,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_wdata,
    output logic              s0_gnt,
    output logic              s1_gnt,
    output logic              s0_done,
    output logic              s1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              cache_hit,
    output logic              busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    state_t        state, state_nxt;
    owner_t        own, own_nxt;
    logic          we_q;
    logic [SW-1:0] starve;
    logic          grant, capture, load_cnt, dec_cnt, cnt_at_one;
    logic          starved;

    assign starved = (starve == SW'(STARVE_MAX));

    always_comb begin
        state_nxt = state;
        own_nxt   = own;
        grant     = 1'b0;
        capture   = 1'b0;
        load_cnt  = 1'b0;
        dec_cnt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (s1_req && !(s0_req && starved)) begin
                    grant     = 1'b1;
                    own_nxt   = OWN_S1;
                    state_nxt = ST_ACCESS;
                end else if (s0_req) begin
                    grant     = 1'b1;
                    own_nxt   = OWN_S0;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (cache_hit) begin
                    capture   = !we_q;
                    state_nxt = ST_DONE;
                end else begin
                    load_cnt  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dec_cnt = 1'b1;
                if (cnt_at_one) begin
                    capture   = !we_q;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_IDLE;
            own       <= OWN_S0;
            we_q      <= 1'b0;
            starve    <= '0;
            s0_gnt    <= 1'b0;
            s1_gnt    <= 1'b0;
            s0_done   <= 1'b0;
            s1_done   <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state   <= state_nxt;
            own     <= own_nxt;
            busy    <= (state_nxt != ST_IDLE);
            s0_gnt  <= (state_nxt != ST_IDLE) && (own_nxt == OWN_S0);
            s1_gnt  <= (state_nxt != ST_IDLE) && (own_nxt == OWN_S1);
            s0_done <= (state_nxt == ST_DONE) && (own_nxt == OWN_S0);
            s1_done <= (state_nxt == ST_DONE) && (own_nxt == OWN_S1);
            mem_en  <= grant;
            mem_we  <= grant && ((own_nxt == OWN_S1) ? s1_we : s0_we);
            if (grant) begin
                we_q      <= (own_nxt == OWN_S1) ? s1_we : s0_we;
                mem_addr  <= (own_nxt == OWN_S1) ? s1_addr : s0_addr;
                mem_wdata <= (own_nxt == OWN_S1) ? s1_wdata : s0_wdata;
                if (own_nxt == OWN_S0) begin
                    starve <= '0;
                end else if (s0_req && !starved) begin
                    starve <= starve + SW'(1);
                end
            end
            if (capture) begin
                rdata <= mem_rdata;
            end
        end
    end

    miss_wait_counter #(.W(CNT_W)) u_miss_wait (
        .clk      (clk),
        .clr      (clr),
        .load     (load_cnt),
        .load_val (CNT_W'(MISS_WAIT)),
        .dec      (dec_cnt),
        .at_one   (cnt_at_one)
    );

endmodule

// File: tb/tb_stage_mem_arbiter.sv
// Directed bench for stage_mem_arbiter: hit/miss reads, writes, priority and starvation order,
// reset during a miss, and a request dropped after grant.
module tb_stage_mem_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       s0_req, s0_we, s1_req, s1_we;
    logic [7:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic       s0_gnt, s1_gnt, s0_done, s1_done;
    logic [7:0] rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       cache_hit, busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stage_mem_arbiter #(
        .ADDR_W(8), .DATA_W(8), .MISS_WAIT(4), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .clr(clr),
        .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s0_gnt(s0_gnt), .s1_gnt(s1_gnt), .s0_done(s0_done), .s1_done(s1_done),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cache_hit(cache_hit), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic       exp_own [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int         k;
    logic       prev0, prev1, both_hi;

    initial begin
        clr = 1'b0;
        {s0_req, s0_we, s1_req, s1_we} = '0;
        {s0_addr, s0_wdata, s1_addr, s1_wdata} = '0;
        mem_rdata = 8'h00;
        cache_hit = 1'b0;
        #13;
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'({s0_gnt, s1_gnt}), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_rdata", 32'(rdata), 0);
        clr = 1'b1;
        tick();

        // s1 read hit
        s1_req = 1'b1; s1_we = 1'b0; s1_addr = 8'h20;
        cache_hit = 1'b1; mem_rdata = 8'h5A;
        tick();
        check("t1_s1_gnt", 32'(s1_gnt), 1);
        check("t1_s0_gnt", 32'(s0_gnt), 0);
        check("t1_mem_en", 32'(mem_en), 1);
        check("t1_mem_addr", 32'(mem_addr), 32'h20);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_mem_en_c2", 32'(mem_en), 0);
        check("t1_done_c2", 32'(s1_done), 0);
        tick();
        check("t1_done_c3", 32'(s1_done), 1);
        check("t1_rdata", 32'(rdata), 32'h5A);
        s1_req = 1'b0;
        tick();
        check("t1_done_c4", 32'(s1_done), 0);
        check("t1_gnt_c4", 32'(s1_gnt), 0);
        check("t1_busy_c4", 32'(busy), 0);

        // s1 write hit, rdata must hold
        s1_req = 1'b1; s1_we = 1'b1; s1_addr = 8'h33; s1_wdata = 8'h99;
        mem_rdata = 8'hEE;
        tick();
        check("t4_mem_we", 32'(mem_we), 1);
        check("t4_mem_wdata", 32'(mem_wdata), 32'h99);
        check("t4_mem_addr", 32'(mem_addr), 32'h33);
        tick(2);
        check("t4_done", 32'(s1_done), 1);
        check("t4_rdata_hold", 32'(rdata), 32'h5A);
        s1_req = 1'b0; s1_we = 1'b0;
        tick();

        // s0 read miss
        s0_req = 1'b1; s0_addr = 8'h10; cache_hit = 1'b0; mem_rdata = 8'h11;
        tick();
        check("t2_s0_gnt", 32'(s0_gnt), 1);
        check("t2_mem_addr", 32'(mem_addr), 32'h10);
        tick(2);
        check("t2_busy_c3", 32'(busy), 1);
        tick(3);
        check("t2_done_c6", 32'(s0_done), 0);
        mem_rdata = 8'hC3;
        tick();
        check("t2_done_c7", 32'(s0_done), 1);
        check("t2_rdata", 32'(rdata), 32'hC3);
        check("t2_busy_c7", 32'(busy), 1);
        s0_req = 1'b0;
        tick();
        check("t2_busy_c8", 32'(busy), 0);
        check("t2_done_c8", 32'(s0_done), 0);

        // reset during the miss wait, then re-issue
        s0_req = 1'b1; s0_addr = 8'h40; mem_rdata = 8'h77;
        tick(4);
        check("t5_busy_pre", 32'(busy), 1);
        clr = 1'b0;
        #1;
        check("t5_gnt", 32'({s0_gnt, s1_gnt}), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(s0_done), 0);
        check("t5_rdata", 32'(rdata), 0);
        #2;
        clr = 1'b1;
        tick();
        check("t5_regnt", 32'(s0_gnt), 1);
        tick(5);
        check("t5_done_c6", 32'(s0_done), 0);
        tick();
        check("t5_done_c7", 32'(s0_done), 1);
        check("t5_rdata_77", 32'(rdata), 32'h77);
        s0_req = 1'b0;
        tick();

        // s1 dropped during CHECK with s0 pending
        s1_req = 1'b1; s1_addr = 8'h50; s0_req = 1'b1; s0_addr = 8'h60;
        cache_hit = 1'b1; mem_rdata = 8'hA5;
        tick();
        check("t6_s1_gnt", 32'({s0_gnt, s1_gnt}), 32'b01);
        tick();
        s1_req = 1'b0;
        tick();
        check("t6_s1_done", 32'(s1_done), 1);
        check("t6_rdata", 32'(rdata), 32'hA5);
        tick();
        check("t6_s1_done_once", 32'(s1_done), 0);
        tick();
        check("t6_s0_gnt", 32'({s0_gnt, s1_gnt}), 32'b10);
        check("t6_s0_addr", 32'(mem_addr), 32'h60);
        mem_rdata = 8'h3C;
        tick(2);
        check("t6_s0_done", 32'(s0_done), 1);
        check("t6_s0_rdata", 32'(rdata), 32'h3C);
        s0_req = 1'b0;
        tick();

        // both held: starvation order
        s0_req = 1'b1; s1_req = 1'b1; s0_addr = 8'h01; s1_addr = 8'h02;
        k = 0; prev0 = 1'b0; prev1 = 1'b0; both_hi = 1'b0;
        for (int c = 0; c < 60 && k < 8; c++) begin
            tick();
            if (s0_gnt && s1_gnt) both_hi = 1'b1;
            if ((s0_gnt && !prev0) || (s1_gnt && !prev1)) begin
                check($sformatf("t3_order%0d", k), 32'(s1_gnt), 32'(exp_own[k]));
                k++;
            end
            prev0 = s0_gnt; prev1 = s1_gnt;
        end
        check("t3_grants", 32'(k), 8);
        check("t3_both_gnt", 32'(both_hi), 0);
        s0_req = 1'b0; s1_req = 1'b0;
        tick(5);
        check("t3_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
